// File: rtl/qs_sort_bank.sv
// qs_sort_bank: streaming sort bank.
// Loads a batch of 1..N words into a register array and pads the unused tail.
// Sorts the array in place with N phases of odd-even transposition, then
// streams the first cnt entries out in sorted order.
module qs_sort_bank #(
    parameter int N      = 16,
    parameter int W      = 32,
    parameter int ASCEND = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         in_last,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         out_last,
    input  logic         out_rdy,
    output logic         busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = $clog2(N);

    // Pad must sort to the tail: all-ones when ascending, all-zeros when descending.
    localparam logic [W-1:0] PAD = (ASCEND != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SORT   = 2'd1,
        S_UNLOAD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   p_q, p_d;
    logic [W-1:0]       arr_q [N];
    logic [W-1:0]       arr_d [N];

    logic               in_acc_s;
    logic               load_done_s;
    logic               sort_done_s;
    logic               out_acc_s;
    logic               at_last_s;

    // True when the pair (a, b) is out of order for the configured direction.
    // Equal words are never reported, so they are never swapped.
    function automatic logic out_of_order(input logic [W-1:0] a, input logic [W-1:0] b);
        if (ASCEND != 0) begin
            return (a > b);
        end else begin
            return (a < b);
        end
    endfunction

    assign in_acc_s    = (state_q == S_LOAD) & in_vld;
    // The N-th accepted word closes the batch even without in_last.
    assign load_done_s = in_acc_s & (in_last | (cnt_q == CNT_W'(N - 1)));
    assign sort_done_s = (state_q == S_SORT) & (p_q == IDX_W'(N - 1));
    assign out_acc_s   = (state_q == S_UNLOAD) & out_rdy;
    assign at_last_s   = (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: LOAD -> SORT -> UNLOAD -> LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (load_done_s) begin
                    state_d = S_SORT;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SORT: begin
                if (sort_done_s) begin
                    state_d = S_UNLOAD;
                end else begin
                    state_d = S_SORT;
                end
            end
            S_UNLOAD: begin
                if (out_acc_s && at_last_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_UNLOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Output decode, driven only by registered state so every output is glitch-free.
    always_comb begin
        in_rdy   = 1'b0;
        out_vld  = 1'b0;
        out_last = 1'b0;
        busy     = 1'b0;
        out_dat  = {W{1'b0}};
        case (state_q)
            S_LOAD: begin
                in_rdy = 1'b1;
            end
            S_SORT: begin
                busy = 1'b1;
            end
            S_UNLOAD: begin
                busy     = 1'b1;
                out_vld  = 1'b1;
                out_last = at_last_s;
                out_dat  = arr_q[idx_q];
            end
            default: begin
                in_rdy = 1'b0;
            end
        endcase
    end

    // Batch length, unload index and sort phase for the next cycle.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        p_d   = p_q;
        case (state_q)
            S_LOAD: begin
                idx_d = {IDX_W{1'b0}};
                p_d   = {IDX_W{1'b0}};
                if (in_acc_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_SORT: begin
                if (sort_done_s) begin
                    p_d = {IDX_W{1'b0}};
                end else begin
                    p_d = p_q + IDX_W'(1);
                end
            end
            S_UNLOAD: begin
                if (out_acc_s && at_last_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    idx_d = {IDX_W{1'b0}};
                end else if (out_acc_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
                idx_d = {IDX_W{1'b0}};
                p_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Counter registers; a reset discards any partial batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
            p_q   <= {IDX_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            p_q   <= p_d;
        end
    end

    // Array update: write accepted words plus tail padding while loading;
    // one compare-exchange phase per cycle while sorting.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            arr_d[i] = arr_q[i];
        end
        case (state_q)
            S_LOAD: begin
                if (in_acc_s) begin
                    for (int i = 0; i < N; i++) begin
                        if (CNT_W'(i) == cnt_q) begin
                            arr_d[i] = in_dat;
                        end else if (load_done_s && (CNT_W'(i) > cnt_q)) begin
                            arr_d[i] = PAD;
                        end else begin
                            arr_d[i] = arr_q[i];
                        end
                    end
                end else begin
                    arr_d[0] = arr_q[0];
                end
            end
            S_SORT: begin
                // Pairs starting at an index with the phase parity are disjoint.
                for (int i = 0; i < N - 1; i++) begin
                    if ((i[0] == p_q[0]) && out_of_order(arr_q[i], arr_q[i+1])) begin
                        arr_d[i]   = arr_q[i+1];
                        arr_d[i+1] = arr_q[i];
                    end else begin
                        arr_d[i] = arr_d[i];
                    end
                end
            end
            default: begin
                arr_d[0] = arr_q[0];
            end
        endcase
    end

    // Array storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            arr_q[i] <= arr_d[i];
        end
    end

endmodule

// File: tb/tb_qs_sort_bank.sv
// Directed bench for qs_sort_bank with N=4, W=8.
// An ascending and a descending instance share all inputs, so every batch
// checks both sort directions at once.
module tb_qs_sort_bank;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic [W-1:0] in_dat;
    logic         in_last;
    logic         out_rdy;

    logic         in_rdy_a, out_vld_a, out_last_a, busy_a;
    logic [W-1:0] out_dat_a;
    logic         in_rdy_d, out_vld_d, out_last_d, busy_d;
    logic [W-1:0] out_dat_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qs_sort_bank #(.N(N), .W(W), .ASCEND(1)) u_asc (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last),
        .in_rdy(in_rdy_a), .out_vld(out_vld_a), .out_dat(out_dat_a),
        .out_last(out_last_a), .out_rdy(out_rdy), .busy(busy_a)
    );

    qs_sort_bank #(.N(N), .W(W), .ASCEND(0)) u_desc (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last),
        .in_rdy(in_rdy_d), .out_vld(out_vld_d), .out_dat(out_dat_d),
        .out_last(out_last_d), .out_rdy(out_rdy), .busy(busy_d)
    );

    // Drive n words (word k in bits [8k+7:8k]); called and returns #1 after a posedge.
    task automatic load_batch(input logic [31:0] words, input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            in_vld  = 1'b1;
            in_dat  = words[8*k +: 8];
            in_last = with_last && (k == n - 1);
            @(posedge clk);
            #1;
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_dat  = 8'h00;
    endtask

    // Drain one batch from both instances; returns #1 after the out_last transfer.
    task automatic collect(input bit random_rdy, output logic [31:0] got_a, output logic [31:0] got_d,
                           output int nbeats, output int lastpos, output int lastcnt,
                           output int stable_err, output bit timeout);
        bit           prev_stall;
        bit           done;
        logic [W-1:0] held_a, held_d;
        got_a = 32'h0; got_d = 32'h0; nbeats = 0; lastpos = -1; lastcnt = 0;
        stable_err = 0; timeout = 1'b1; prev_stall = 1'b0; done = 1'b0;
        held_a = 8'h00; held_d = 8'h00;
        for (int cyc = 0; cyc < 200; cyc++) begin
            out_rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_vld_a) begin
                if (prev_stall && ((out_dat_a !== held_a) || (out_dat_d !== held_d))) stable_err++;
                if (out_rdy) begin
                    if (nbeats < N) begin
                        got_a[8*nbeats +: 8] = out_dat_a;
                        got_d[8*nbeats +: 8] = out_dat_d;
                    end
                    if (out_last_a) begin
                        lastpos = nbeats;
                        lastcnt++;
                    end
                    nbeats++;
                end
                prev_stall = !out_rdy;
                held_a = out_dat_a;
                held_d = out_dat_d;
                done = out_rdy && out_last_a;
            end
            @(posedge clk);
            #1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (in_rdy_a !== 1'b1 || in_rdy_d !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b/%b expected 1", in_rdy_a, in_rdy_d); end
        checks++; if (out_vld_a !== 1'b0 || out_vld_d !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b/%b expected 0", out_vld_a, out_vld_d); end
        checks++; if (out_last_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL reset_last_busy: got %b/%b expected 0/0", out_last_a, busy_a); end
        rst = 1'b0;
    endtask

    task automatic test_basic_sort();
        logic [31:0] ga, gd;
        int nb, lp, lc, se, lat;
        bit to;
        load_batch(32'h20401030, 4, 1'b1);
        checks++; if (in_rdy_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL basic_enter_sort: in_rdy %b busy %b expected 0/1", in_rdy_a, busy_a); end
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (out_vld_a) begin
                lat = c;
                break;
            end
        end
        checks++; if (lat != N) begin errors++; $display("FAIL basic_latency: first out_vld %0d edges after last accept, expected %0d", lat, N); end
        collect(1'b0, ga, gd, nb, lp, lc, se, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got %b expected 0", to); end
        checks++; if (ga !== 32'h40302010) begin errors++; $display("FAIL basic_asc: got %h expected 40302010", ga); end
        checks++; if (gd !== 32'h10203040) begin errors++; $display("FAIL basic_desc: got %h expected 10203040", gd); end
        checks++; if (nb != 4 || lp != 3 || lc != 1) begin errors++; $display("FAIL basic_beats: beats %0d lastpos %0d lastcnt %0d expected 4/3/1", nb, lp, lc); end
        checks++; if (in_rdy_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL basic_return_load: in_rdy %b busy %b expected 1/0", in_rdy_a, busy_a); end
    endtask

    task automatic test_short_batch();
        logic [31:0] ga, gd;
        int nb, lp, lc, se;
        bit to;
        load_batch(32'h0000FF05, 2, 1'b1);
        collect(1'b0, ga, gd, nb, lp, lc, se, to);
        checks++; if (to) begin errors++; $display("FAIL short_timeout: got %b expected 0", to); end
        checks++; if (ga[15:0] !== 16'hFF05) begin errors++; $display("FAIL short_asc: got %h expected ff05", ga[15:0]); end
        checks++; if (gd[15:0] !== 16'h05FF) begin errors++; $display("FAIL short_desc: got %h expected 05ff", gd[15:0]); end
        checks++; if (nb != 2 || lp != 1 || lc != 1) begin errors++; $display("FAIL short_beats: beats %0d lastpos %0d lastcnt %0d expected 2/1/1", nb, lp, lc); end
    endtask

    task automatic test_full_no_last();
        logic [31:0] ga, gd;
        int nb, lp, lc, se;
        bit to;
        load_batch(32'h0C0B0D0A, 4, 1'b0);
        checks++; if (in_rdy_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL full_enter_sort: in_rdy %b busy %b expected 0/1", in_rdy_a, busy_a); end
        collect(1'b0, ga, gd, nb, lp, lc, se, to);
        checks++; if (to) begin errors++; $display("FAIL full_timeout: got %b expected 0", to); end
        checks++; if (ga !== 32'h0D0C0B0A) begin errors++; $display("FAIL full_asc: got %h expected 0d0c0b0a", ga); end
        checks++; if (gd !== 32'h0A0B0C0D) begin errors++; $display("FAIL full_desc: got %h expected 0a0b0c0d", gd); end
        checks++; if (nb != 4 || lp != 3 || lc != 1) begin errors++; $display("FAIL full_beats: beats %0d lastpos %0d lastcnt %0d expected 4/3/1", nb, lp, lc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ga, gd;
        int nb, lp, lc, se;
        bit to;
        // Duplicates and words equal to the ascending pad value.
        load_batch(32'h00FF01FF, 3, 1'b1);
        collect(1'b1, ga, gd, nb, lp, lc, se, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got %b expected 0", to); end
        checks++; if (ga[23:0] !== 24'hFFFF01) begin errors++; $display("FAIL bp_asc: got %h expected ffff01", ga[23:0]); end
        checks++; if (gd[23:0] !== 24'h01FFFF) begin errors++; $display("FAIL bp_desc: got %h expected 01ffff", gd[23:0]); end
        checks++; if (nb != 3 || lp != 2 || lc != 1) begin errors++; $display("FAIL bp_beats: beats %0d lastpos %0d lastcnt %0d expected 3/2/1", nb, lp, lc); end
        checks++; if (se != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalled beats, expected 0", se); end
        checks++; if (in_rdy_a !== 1'b1 || out_vld_a !== 1'b0) begin errors++; $display("FAIL bp_return_load: in_rdy %b out_vld %b expected 1/0", in_rdy_a, out_vld_a); end
    endtask

    task automatic test_single_word();
        logic [31:0] ga, gd;
        int nb, lp, lc, se;
        bit to;
        load_batch(32'h00000055, 1, 1'b1);
        collect(1'b0, ga, gd, nb, lp, lc, se, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got %b expected 0", to); end
        checks++; if (ga[7:0] !== 8'h55 || gd[7:0] !== 8'h55) begin errors++; $display("FAIL single_data: got %h/%h expected 55/55", ga[7:0], gd[7:0]); end
        checks++; if (nb != 1 || lp != 0 || lc != 1) begin errors++; $display("FAIL single_beats: beats %0d lastpos %0d lastcnt %0d expected 1/0/1", nb, lp, lc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ga, gd;
        int nb, lp, lc, se;
        bit to;
        bit seen;
        // Reset two cycles into SORT.
        load_batch(32'h04030201, 4, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_rdy_a !== 1'b1 || out_vld_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_sort_state: in_rdy %b out_vld %b busy %b expected 1/0/0", in_rdy_a, out_vld_a, busy_a); end
        load_batch(32'h00001122, 2, 1'b1);
        collect(1'b0, ga, gd, nb, lp, lc, se, to);
        checks++; if (ga[15:0] !== 16'h2211 || gd[15:0] !== 16'h1122 || nb != 2 || to) begin errors++; $display("FAIL rst_sort_batch: asc %h desc %h beats %0d expected 2211/1122/2", ga[15:0], gd[15:0], nb); end
        // Reset after one beat of UNLOAD.
        load_batch(32'hF0E0D0C0, 4, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_vld_a) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_unload_wait: out_vld %b expected 1 within 20 cycles", out_vld_a); end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_rdy_d !== 1'b1 || out_vld_d !== 1'b0 || busy_d !== 1'b0 || out_last_a !== 1'b0) begin errors++; $display("FAIL rst_unload_state: in_rdy %b out_vld %b busy %b expected 1/0/0", in_rdy_d, out_vld_d, busy_d); end
        load_batch(32'h00060309, 3, 1'b1);
        collect(1'b0, ga, gd, nb, lp, lc, se, to);
        checks++; if (ga[23:0] !== 24'h090603 || gd[23:0] !== 24'h030609) begin errors++; $display("FAIL rst_unload_batch: asc %h desc %h expected 090603/030609", ga[23:0], gd[23:0]); end
        checks++; if (nb != 3 || lp != 2 || to) begin errors++; $display("FAIL rst_unload_beats: beats %0d lastpos %0d expected 3/2", nb, lp); end
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_dat  = 8'h00;
        in_last = 1'b0;
        out_rdy = 1'b0;
        test_reset();
        test_basic_sort();
        test_short_batch();
        test_full_no_last();
        test_backpressure();
        test_single_word();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
